asrv32_wb_retire: RTL

ASRV32_WB_RETIRE -- requirements
Module: asrv32_wb_retire

---
 rtl/asrv32_wb_retire.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/asrv32_wb_retire.sv
// Write-back / retire stage: in-order retire queue with load-response matching,
// trap / MRET redirect, and discard of responses belonging to flushed loads.
module asrv32_wb_retire #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    // memory-stage entries
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_is_load,
    input  logic            i_wr_rd_en,
    input  logic [4:0]      i_rd_addr,
    input  logic [XLEN-1:0] i_rd_data,
    input  logic            i_go_to_trap,
    input  logic            i_return_from_trap,
    input  logic [XLEN-1:0] i_trap_address,
    input  logic [XLEN-1:0] i_return_address,
    // in-order load responses
    input  logic            i_ld_valid,
    input  logic [XLEN-1:0] i_ld_data,
    // retire outputs
    output logic            o_wr_rd_en,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_change_pc,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_flush,
    output logic            o_stall,
    output logic [63:0]     o_retired
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef enum logic {StNormal, StDrain} state_e;

    // queue storage
    logic            q_is_load  [DEPTH];
    logic            q_wr_rd_en [DEPTH];
    logic [4:0]      q_rd_addr  [DEPTH];
    logic [XLEN-1:0] q_rd_data  [DEPTH];
    logic            q_trap     [DEPTH];
    logic            q_mret     [DEPTH];
    logic [XLEN-1:0] q_taddr    [DEPTH];
    logic [XLEN-1:0] q_raddr    [DEPTH];

    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] disc_q;
    state_e        state_q;

    logic          accept, retire, redirect, normal_retire;
    logic [CW-1:0] flush_loads;

    logic            head_is_load, head_wr, head_trap, head_mret;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data, head_taddr, head_raddr;

    assign head_is_load = q_is_load[rd_ptr_q];
    assign head_wr      = q_wr_rd_en[rd_ptr_q];
    assign head_rd      = q_rd_addr[rd_ptr_q];
    assign head_data    = q_rd_data[rd_ptr_q];
    assign head_trap    = q_trap[rd_ptr_q];
    assign head_mret    = q_mret[rd_ptr_q];
    assign head_taddr   = q_taddr[rd_ptr_q];
    assign head_raddr   = q_raddr[rd_ptr_q];

    assign o_ready = (count_q < DepthC) && (state_q == StNormal);
    assign o_stall = !o_ready;
    assign accept  = i_valid && o_ready;

    // A load head may only retire on a response that is not owed to a flushed load.
    assign retire        = (count_q != '0) &&
                           (!head_is_load || (i_ld_valid && (disc_q == '0)));
    assign redirect      = retire && (head_trap || head_mret);
    assign normal_retire = retire && !redirect;

    // Count loads dropped by a redirect: younger queued loads plus a same-edge accepted load.
    always_comb begin
        flush_loads = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && q_is_load[rd_ptr_q + PW'(i)]) begin
                flush_loads = flush_loads + CW'(1);
            end
        end
        if (accept && i_is_load) begin
            flush_loads = flush_loads + CW'(1);
        end
    end

    // Queue storage write; contents need no reset since count gates validity.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            q_is_load[wr_ptr_q]  <= i_is_load;
            q_wr_rd_en[wr_ptr_q] <= i_wr_rd_en;
            q_rd_addr[wr_ptr_q]  <= i_rd_addr;
            q_rd_data[wr_ptr_q]  <= i_rd_data;
            q_trap[wr_ptr_q]     <= i_go_to_trap;
            q_mret[wr_ptr_q]     <= i_return_from_trap;
            q_taddr[wr_ptr_q]    <= i_trap_address;
            q_raddr[wr_ptr_q]    <= i_return_address;
        end
    end

    // Queue pointers, discard counter and NORMAL/DRAIN state machine.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            disc_q   <= '0;
            state_q  <= StNormal;
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            disc_q   <= flush_loads;
            state_q  <= StDrain;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (retire) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(accept) - CW'(retire);
            if (i_ld_valid && (disc_q != '0)) begin
                disc_q <= disc_q - CW'(1);
            end
            if (state_q == StDrain) begin
                if ((disc_q == '0) || ((disc_q == CW'(1)) && i_ld_valid)) begin
                    state_q <= StNormal;
                end
            end
        end
    end

    // Registered retire outputs: regfile write, redirect pulse and retire counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wr_rd_en  <= 1'b0;
            o_rd_addr   <= '0;
            o_rd_data   <= '0;
            o_change_pc <= 1'b0;
            o_flush     <= 1'b0;
            o_next_pc   <= PC_RESET;
            o_retired   <= '0;
        end else begin
            o_wr_rd_en  <= normal_retire && head_wr && (head_rd != '0);
            o_change_pc <= redirect;
            o_flush     <= redirect;
            if (normal_retire) begin
                o_rd_addr <= head_rd;
                o_rd_data <= head_is_load ? i_ld_data : head_data;
            end
            if (redirect) begin
                o_next_pc <= head_trap ? head_taddr : head_raddr;
            end
            // MRET counts as retired; a trapping entry does not.
            if (normal_retire || (redirect && !head_trap)) begin
                o_retired <= o_retired + 64'd1;
            end
        end
    end

endmodule
